// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared I$ geometry constants and controller state encoding
package segre_pkg;

    localparam int ADDR_SIZE          = 32;
    localparam int ICACHE_BYTE_SIZE   = 6;
    localparam int ICACHE_TAG_SIZE    = ADDR_SIZE - ICACHE_BYTE_SIZE;
    localparam int ICACHE_INDEX_SIZE  = 2;
    localparam int ICACHE_NUM_LANES   = 4;

    typedef enum logic [2:0] {
        ICTRL_IDLE      = 3'd0,
        ICTRL_LOOKUP    = 3'd1,
        ICTRL_MISS_REQ  = 3'd2,
        ICTRL_MISS_WAIT = 3'd3,
        ICTRL_FILL      = 3'd4,
        ICTRL_FENCE     = 3'd5
    } icache_ctrl_state_e;

endpackage

// File: rtl/segre_icache_ctrl.sv
// rtl/segre_icache_ctrl.sv - I$ tag-store sequencer: lookup, MMU refill, round-robin fill, fence
module segre_icache_ctrl
    import segre_pkg::*;
#(
    parameter int ADDR_SIZE_P = ADDR_SIZE,
    parameter int BYTE_SIZE   = ICACHE_BYTE_SIZE,
    parameter int TAG_SIZE    = ADDR_SIZE_P - BYTE_SIZE,
    parameter int INDEX_SIZE  = ICACHE_INDEX_SIZE,
    parameter int NUM_LANES   = ICACHE_NUM_LANES
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   fetch_req_i,
    input  logic [ADDR_SIZE_P-1:0] fetch_addr_i,
    output logic                   fetch_ready_o,
    output logic                   fetch_valid_o,
    output logic [INDEX_SIZE-1:0]  fetch_lane_o,
    input  logic                   kill_i,
    input  logic                   fence_i,
    output logic                   fence_done_o,
    output logic                   tag_req_o,
    output logic [TAG_SIZE-1:0]    tag_tag_o,
    output logic [INDEX_SIZE-1:0]  tag_index_o,
    output logic                   tag_fill_o,
    output logic                   tag_invalidate_o,
    input  logic                   tag_hit_i,
    input  logic                   tag_miss_i,
    input  logic [INDEX_SIZE-1:0]  tag_lane_i,
    output logic                   mmu_req_o,
    output logic [ADDR_SIZE_P-1:0] mmu_addr_o,
    input  logic                   mmu_gnt_i,
    input  logic                   mmu_data_valid_i
);

    icache_ctrl_state_e      state;
    logic [TAG_SIZE-1:0]     tag_q;
    logic [INDEX_SIZE-1:0]   victim;
    logic                    killed;
    logic                    unused_offset;

    // Only whole lines are tracked; the byte offset never leaves the fetch stage.
    assign unused_offset = ^fetch_addr_i[BYTE_SIZE-1:0];

    assign fetch_ready_o    = (state == ICTRL_IDLE) && !fence_i;
    assign tag_req_o        = (state == ICTRL_LOOKUP);
    assign tag_fill_o       = (state == ICTRL_FILL);
    assign tag_invalidate_o = (state == ICTRL_FENCE);
    assign tag_tag_o        = tag_q;
    assign tag_index_o      = (state == ICTRL_FILL) ? victim : '0;
    assign mmu_req_o        = (state == ICTRL_MISS_REQ);
    assign mmu_addr_o       = {tag_q, {BYTE_SIZE{1'b0}}};

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state         <= ICTRL_IDLE;
            tag_q         <= '0;
            victim        <= '0;
            killed        <= 1'b0;
            fetch_valid_o <= 1'b0;
            fetch_lane_o  <= '0;
            fence_done_o  <= 1'b0;
        end else begin
            fetch_valid_o <= 1'b0;
            fence_done_o  <= 1'b0;
            case (state)
                ICTRL_IDLE: begin
                    // fence_i is still high while its done pulse is out; don't fence twice.
                    if (fence_i && !fence_done_o) begin
                        state <= ICTRL_FENCE;
                    end else if (fetch_req_i && fetch_ready_o) begin
                        tag_q <= fetch_addr_i[ADDR_SIZE_P-1:BYTE_SIZE];
                        state <= ICTRL_LOOKUP;
                    end
                end
                ICTRL_LOOKUP: begin
                    if (kill_i) begin
                        state <= ICTRL_IDLE;
                    end else if (tag_hit_i) begin
                        fetch_valid_o <= 1'b1;
                        fetch_lane_o  <= tag_lane_i;
                        state         <= ICTRL_IDLE;
                    end else if (tag_miss_i) begin
                        state <= ICTRL_MISS_REQ;
                    end
                end
                ICTRL_MISS_REQ: begin
                    // Once granted the response is coming regardless, so it must be absorbed.
                    if (mmu_gnt_i) begin
                        state <= ICTRL_MISS_WAIT;
                        if (kill_i) begin
                            killed <= 1'b1;
                        end
                    end else if (kill_i) begin
                        state <= ICTRL_IDLE;
                    end
                end
                ICTRL_MISS_WAIT: begin
                    if (kill_i) begin
                        killed <= 1'b1;
                    end
                    if (mmu_data_valid_i) begin
                        state <= ICTRL_FILL;
                    end
                end
                ICTRL_FILL: begin
                    victim <= (victim == INDEX_SIZE'(NUM_LANES - 1)) ? '0 : victim + 1'b1;
                    if (killed || kill_i) begin
                        killed <= 1'b0;
                        state  <= ICTRL_IDLE;
                    end else begin
                        state <= ICTRL_LOOKUP;
                    end
                end
                ICTRL_FENCE: begin
                    victim       <= '0;
                    fence_done_o <= 1'b1;
                    state        <= ICTRL_IDLE;
                end
                default: state <= ICTRL_IDLE;
            endcase
        end
    end

endmodule
